adc_scan_sequencer: RTL
=======================

# adc_scan_sequencer

Scheduler that owns the shared external ADC and time-multiplexes it across the analog channels. It steps through a compile-time channel mask, drives the channel select, waits a settling interval, and issues a conversion start. It captures each tagged result into a per-channel holding register, which feeds the downstream channel demux/consumers. Sits between the ADC interface logic and the per-channel sample consumers.

## Interface
- CH_MASK, 10'b11_1111_0011, enabled channels (bit k = channel k); default scans 0,1,4,5,6,7,8,9
- SETTLE_CYC, 16, cycles the channel select is held before conversion start (1..255)
- TIMEOUT_CYC, 255, max cycles waited for a result (used only with ADC_TIMEOUT_EN; 1..65535)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- enable  in  1  level; high = scan continuously
- channel  out  8  current channel select to ADC mux
- conv_start  out  1  one-cycle pulse requesting a conversion on `channel`
- new_sample  in  1  one-cycle strobe: `sample`/`sample_channel` valid
- sample  in  8  conversion result
- sample_channel  in  8  channel tag of result
- samples  out  80  packed holding registers, channel k at [8k+7:8k]
- valid  out  10  sticky per-channel: at least one good sample stored since reset
- err  out  10  sticky per-channel: tag mismatch or timeout occurred
- scan_done  out  1  one-cycle pulse when the last enabled channel of a pass completes
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, SETTLE, START, WAIT, NEXT.
- IDLE: when enable=1, go to SETTLE.
- SETTLE: a counter counts SETTLE_CYC cycles, then goes to START.
- START: conv_start=1 for exactly this one cycle, then goes to WAIT.
- WAIT, on new_sample, tag match (sample_channel == channel): samples[channel] <= sample and valid[channel] <= 1, then NEXT.
- WAIT, on new_sample, tag mismatch (including tags >= 10): err[channel] <= 1, samples unchanged, then NEXT.
- NEXT: channel <= next set bit of CH_MASK above current, wrapping to the lowest. Wrapping, or a single-bit mask, pulses scan_done. Then SETTLE if enable=1, else IDLE.
- enable low mid-scan: the current channel finishes (through NEXT), then IDLE. Channel is held at the advanced value; a re-enable resumes there.
- new_sample outside WAIT: ignored, no flag.
- new_sample in the same cycle WAIT is entered: not possible, because WAIT is entered from START.
- CH_MASK=0 is illegal; the block stays in IDLE permanently.
- Reset values: channel = lowest set bit of CH_MASK (0 for default), conv_start=0, samples=0, valid=0, err=0, scan_done=0, busy=0, state IDLE, counters 0.
- Reset asserted mid-operation: immediate return to reset values. A result arriving after reset deasserts is ignored, since the block is no longer in WAIT.

## Timing
- enable rises in cycle T (IDLE): SETTLE during T+1..T+SETTLE_CYC; conv_start high in T+SETTLE_CYC+1.
- new_sample in cycle W: samples/valid/err update visible in W+1 (NEXT state); channel advances visible in W+2.
- scan_done is asserted in the same cycle that the channel change becomes visible.
- Minimum per-channel period is SETTLE_CYC + 3 + ADC latency.

## Configuration
- ADC_TIMEOUT_EN defined: WAIT counts cycles. If TIMEOUT_CYC cycles elapse with no new_sample, err[channel] <= 1 and the block goes to NEXT; a late result is ignored.
- ADC_TIMEOUT_EN not defined: no timeout counter; WAIT holds indefinitely until new_sample; err reflects tag mismatches only.

## Structure
- Shared package adc_pkg holds:
  - NUM_CH=10, CH_W=8, SMP_W=8
  - the state enumeration
  - the default CH_MASK constant
- Sub-module adc_next_ch: combinational wrap-around priority finder. Inputs are mask and current index; outputs are next index and a wrap flag. It is reused by other scanners.

## Test plan
- Default mask, SETTLE_CYC=16, enable=1, ADC model answers 5 cycles after each conv_start with sample=8'hA0+ch and a correct tag -> channel sequence 0,1,4,5,6,7,8,9,0; samples[ch]=A0+ch; valid=10'h3F3; one scan_done per pass.
- ADC answers channel 5 with sample_channel=6 -> err[5]=1; samples[5] and samples[6] are unchanged; the scan continues to 6.
- With ADC_TIMEOUT_EN and TIMEOUT_CYC=20, ADC silent on channel 4 -> after 20 WAIT cycles err[4]=1 and the block moves to 5. A new_sample then injected in IDLE/SETTLE is ignored.
- enable dropped while WAIT on channel 7 -> result stored; block goes to IDLE with channel=8. Re-enable -> first conv_start is for channel 8.
- rst pulled low during SETTLE on channel 6 -> all outputs return to reset values the same cycle. After release with enable=1, the scan restarts at channel 0.
- Back-to-back: new_sample held high for 3 cycles -> only one store occurs per conv_start.

Source files
------------

// File: rtl/adc_pkg.sv
// adc_pkg: channel geometry, scan state encoding and
// mask helpers shared by the ADC scan sequencer family.
package adc_pkg;

  localparam int unsigned NUM_CH = 10;
  localparam int unsigned CH_W   = 8;
  localparam int unsigned SMP_W  = 8;

  localparam logic [NUM_CH-1:0] DEF_CH_MASK =
    10'b11_1111_0011;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_START  = 3'd2,
    S_WAIT   = 3'd3,
    S_NEXT   = 3'd4
  } adc_state_e;

  // Lowest set bit of a channel mask; 0 for an empty mask.
  function automatic logic [CH_W-1:0] lowest_ch(
    input logic [NUM_CH-1:0] mask
  );
    logic [CH_W-1:0] r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i]) r = CH_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/adc_next_ch.sv
// adc_next_ch: wrap-around priority finder returning the
// next set mask bit above the current channel index.
module adc_next_ch
  import adc_pkg::*;
(
  input  logic [NUM_CH-1:0] mask_i,
  input  logic [CH_W-1:0]   cur_i,
  output logic [CH_W-1:0]   nxt_o,
  output logic              wrap_o
);

  logic found;

  // Scan upward from cur_i+1; fall back to the lowest bit.
  always_comb begin
    found  = 1'b0;
    nxt_o  = lowest_ch(mask_i);
    wrap_o = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && mask_i[i] && (CH_W'(i) > cur_i)) begin
        found  = 1'b1;
        nxt_o  = CH_W'(i);
        wrap_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer: time-multiplexes one ADC over CH_MASK.
// Define ADC_TIMEOUT_EN to abandon silent conversions.
module adc_scan_sequencer
  import adc_pkg::*;
#(
  parameter logic [NUM_CH-1:0] CH_MASK     = DEF_CH_MASK,
  parameter int unsigned       SETTLE_CYC  = 16,
  parameter int unsigned       TIMEOUT_CYC = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  output logic [CH_W-1:0]         channel,
  output logic                    conv_start,
  input  logic                    new_sample,
  input  logic [SMP_W-1:0]        sample,
  input  logic [CH_W-1:0]         sample_channel,
  output logic [NUM_CH*SMP_W-1:0] samples,
  output logic [NUM_CH-1:0]       valid,
  output logic [NUM_CH-1:0]       err,
  output logic                    scan_done,
  output logic                    busy
);

  localparam int unsigned CNT_MAX =
    (TIMEOUT_CYC > SETTLE_CYC) ? TIMEOUT_CYC : SETTLE_CYC;
  localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);
  localparam int unsigned IDX_W = $clog2(NUM_CH);

  localparam logic [CNT_W-1:0] SETTLE_LAST =
    CNT_W'(SETTLE_CYC - 1);
`ifdef ADC_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST =
    CNT_W'(TIMEOUT_CYC - 1);
`endif

  localparam logic [CH_W-1:0] RST_CH = lowest_ch(CH_MASK);
  localparam logic MASK_OK = |CH_MASK;

  adc_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CH_W-1:0]  chan_q, chan_d;
  logic [NUM_CH-1:0][SMP_W-1:0] smp_q, smp_d;
  logic [NUM_CH-1:0] valid_q, valid_d;
  logic [NUM_CH-1:0] err_q, err_d;
  logic done_q, done_d;

  logic [CH_W-1:0]  nxt_ch;
  logic             nxt_wrap;
  logic [IDX_W-1:0] idx;

  assign idx = chan_q[IDX_W-1:0];

  adc_next_ch u_next_ch (
    .mask_i (CH_MASK),
    .cur_i  (chan_q),
    .nxt_o  (nxt_ch),
    .wrap_o (nxt_wrap)
  );

  // State, counter, channel and holding registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      chan_q  <= RST_CH;
      smp_q   <= '0;
      valid_q <= '0;
      err_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      chan_q  <= chan_d;
      smp_q   <= smp_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  // Scan FSM: settle, start, wait for result, advance.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    chan_d  = chan_q;
    smp_d   = smp_q;
    valid_d = valid_q;
    err_d   = err_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (enable && MASK_OK) state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = S_START;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (new_sample) begin
          if (sample_channel == chan_q) begin
            smp_d[idx]   = sample;
            valid_d[idx] = 1'b1;
          end else begin
            err_d[idx] = 1'b1;
          end
          cnt_d   = '0;
          state_d = S_NEXT;
        end
`ifdef ADC_TIMEOUT_EN
        else if (cnt_q == TIMEOUT_LAST) begin
          err_d[idx] = 1'b1;
          cnt_d      = '0;
          state_d    = S_NEXT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_NEXT: begin
        chan_d  = nxt_ch;
        done_d  = nxt_wrap;
        cnt_d   = '0;
        state_d = enable ? S_SETTLE : S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign channel    = chan_q;
  assign conv_start = (state_q == S_START);
  assign samples    = smp_q;
  assign valid      = valid_q;
  assign err        = err_q;
  assign scan_done  = done_q;
  assign busy       = (state_q != S_IDLE);

endmodule
